// File: rtl/serial_mag_comparator_pkg.sv
// Shared state encodings, default operand width and verdict helper for the
// serial magnitude comparator.
package serial_mag_comparator_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Packs {gt, eq, lt}; lt is implied by neither gt nor eq.
  function automatic logic [2:0] verdict(input logic g, input logic e);
    return {g, e, ~g & ~e};
  endfunction

endpackage

// File: rtl/serial_mag_comparator_comp2_slice.sv
// Combinational 2-bit unsigned compare: x > y and x == y.
// Zero latency; no handshake.
module comp2_slice (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       gt,
  output logic       eq
);

  assign gt = (x[1] & ~y[1]) | ((x[1] ~^ y[1]) & x[0] & ~y[0]);
  assign eq = (x == y);

endmodule

// File: rtl/serial_mag_comparator.sv
// MSB-first iterative unsigned compare, two bits per cycle; result after WIDTH/2 cycles.
// Accepts operands only in IDLE; holds gt/eq/lt stable in DONE until res_ready.
module serial_mag_comparator
  import serial_mag_comparator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH/2 + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH/2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic             gt_acc_q, gt_acc_d;
  logic             eq_acc_q, eq_acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic slice_gt;
  logic slice_eq;

  comp2_slice u_slice (
    .x  (sh_a_q[WIDTH-1:WIDTH-2]),
    .y  (sh_b_q[WIDTH-1:WIDTH-2]),
    .gt (slice_gt),
    .eq (slice_eq)
  );

  always_comb begin
    state_d  = state_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    gt_acc_d = gt_acc_q;
    eq_acc_d = eq_acc_q;
    cnt_d    = cnt_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;

    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          sh_a_d   = a;
          sh_b_d   = b;
          gt_acc_d = 1'b0;
          eq_acc_d = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        // Once a pair differs the verdict is frozen; later pairs cannot change it.
        if (eq_acc_q) begin
          gt_acc_d = slice_gt;
          eq_acc_d = slice_eq;
        end
        sh_a_d = sh_a_q << 2;
        sh_b_d = sh_b_q << 2;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          {gt_d, eq_d, lt_d} = verdict(gt_acc_d, eq_acc_d);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      gt_acc_q <= 1'b0;
      eq_acc_q <= 1'b0;
      cnt_q    <= '0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      gt_acc_q <= gt_acc_d;
      eq_acc_q <= eq_acc_d;
      cnt_q    <= cnt_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign res_valid   = (state_q == ST_DONE);
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign gt          = gt_q;
  assign eq          = eq_q;
  assign lt          = lt_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Randomized and directed checks of serial_mag_comparator at WIDTH=8 against
// a plain-arithmetic reference (a>b, a==b, a<b, fixed WIDTH/2 latency).
module tb_serial_mag_comparator;

  localparam int WIDTH = 8;
  localparam int LAT   = WIDTH / 2;

  logic             clk;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             res_valid;
  logic             res_ready;
  logic             gt;
  logic             eq;
  logic             lt;
  logic             busy;

  int n_cmp;
  int n_err;

  serial_mag_comparator #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .gt          (gt),
    .eq          (eq),
    .lt          (lt),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive at negedge, sample at negedge: outputs are stable half a cycle after each edge.
  task automatic do_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                       input int hold, input bit noise);
    logic eg, ee, el;
    int   j;
    eg = (oa > ob);
    ee = (oa == ob);
    el = (oa < ob);
    a           = oa;
    b           = ob;
    start_valid = 1'b1;
    res_ready   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    check("accept_ready", start_ready, 0);
    check("accept_busy", busy, 1);
    j = 0;
    while (!res_valid && j < 3 * LAT) begin
      if (noise) begin
        start_valid = 1'($urandom_range(0, 1));
        a           = WIDTH'($urandom);
        b           = WIDTH'($urandom);
        res_ready   = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      j++;
    end
    check("latency", j, LAT);
    check("res_gt", gt, eg);
    check("res_eq", eq, ee);
    check("res_lt", lt, el);
    check("onehot", gt + eq + lt, 1);
    for (int h = 0; h < hold; h++) begin
      res_ready   = 1'b0;
      start_valid = ~start_valid;
      a           = WIDTH'($urandom);
      b           = WIDTH'($urandom);
      @(negedge clk);
      check("hold_valid", res_valid, 1);
      check("hold_ready", start_ready, 0);
      check("hold_res", {gt, eq, lt}, {eg, ee, el});
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("post_valid", res_valid, 0);
    check("post_ready", start_ready, 1);
    check("post_busy", busy, 0);
    check("retain_res", {gt, eq, lt}, {eg, ee, el});
  endtask

  initial begin
    int seen;
    logic [WIDTH-1:0] ra, rb;
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b1;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    a           = '0;
    b           = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", start_ready, 1);
    check("rst_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_res", {gt, eq, lt}, 3'b000);
    rst = 1'b0;
    @(negedge clk);

    do_op(8'hA5, 8'hA4, 0, 1'b0);
    do_op(8'h3C, 8'h3C, 0, 1'b0);
    do_op(8'h01, 8'h80, 0, 1'b0);
    do_op(8'h5A, 8'hC3, 3, 1'b0);

    // Reset two cycles into RUN: no result may ever appear.
    a           = 8'h77;
    b           = 8'h12;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_ready", start_ready, 1);
    check("mrst_valid", res_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_res", {gt, eq, lt}, 3'b000);
    seen = 0;
    repeat (2 * LAT) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check("mrst_no_result", seen, 0);

    do_op(8'hFF, 8'h00, 0, 1'b0);
    do_op(8'h00, 8'hFF, 0, 1'b0);

    do_op(8'h00, 8'h00, 0, 1'b0);
    do_op(8'hFF, 8'hFF, 1, 1'b0);
    do_op(8'h80, 8'h7F, 0, 1'b0);
    do_op(8'hC1, 8'hC2, 2, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
      do_op(ra, rb, $urandom_range(0, 3), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
